hammer_swing_sequencer: RTL and testbench

// - Frame-rate controller that sequences the sprite position datapath through the hammer-throw cycle.
// - Cycle: idle at rest -> circular swing around (CENTER_X,CENTER_Y) -> keyed release into ballistic flight -> landing hold -> idle.
// - Drives sprite_x/sprite_y to the colour mapper in place of free keyboard motion.
// - Consumes the same USB keycode byte as the rest of the design.

---
 rtl/hammer_swing_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_hammer_swing_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/hammer_swing_sequencer.sv
// Hammer-throw sprite sequencer: idle -> circular swing -> keyed ballistic flight -> landing hold.
// Optional `define SWING_ACCEL_EN shortens the step period and strengthens the throw each revolution.
module hammer_swing_sequencer #(
    parameter int         CENTER_X    = 320,
    parameter int         CENTER_Y    = 240,
    parameter int         STEP_FRAMES = 4,
    parameter int         HOLD_FRAMES = 60,
    parameter int         X_MIN       = 0,
    parameter int         X_MAX       = 639,
    parameter int         Y_MIN       = 0,
    parameter int         Y_MAX       = 479,
    parameter logic [7:0] KEY_THROW   = 8'h2C,
    parameter logic [7:0] KEY_ABORT   = 8'h29
) (
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    output logic [9:0] sprite_x,
    output logic [9:0] sprite_y,
    output logic [1:0] state,
    output logic [3:0] angle_idx,
    output logic [7:0] throws
);

    localparam int CNT_MAX = (STEP_FRAMES > HOLD_FRAMES) ? STEP_FRAMES : HOLD_FRAMES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef logic signed [10:0] s11_t;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWING  = 2'd1,
        FLIGHT = 2'd2,
        LANDED = 2'd3
    } state_t;

    localparam logic [9:0]    CX10      = 10'(CENTER_X);
    localparam logic [9:0]    CY10      = 10'(CENTER_Y);
    localparam logic [9:0]    REST_X    = 10'(CENTER_X + 70);
    localparam logic [9:0]    REST_Y    = 10'(CENTER_Y);
    localparam s11_t          XMIN_S    = s11_t'(X_MIN);
    localparam s11_t          XMAX_S    = s11_t'(X_MAX);
    localparam s11_t          YMIN_S    = s11_t'(Y_MIN);
    localparam s11_t          YMAX_S    = s11_t'(Y_MAX);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_FRAMES - 1);
`ifndef SWING_ACCEL_EN
    localparam logic [CW-1:0] STEP_LAST = CW'(STEP_FRAMES - 1);
`endif

    // Radius-70 circle sampled every 22.5 degrees; Y is X rotated a quarter turn.
    function automatic s11_t off_x(input logic [3:0] k);
        case (k)
            4'd0:    return 11'sd70;
            4'd1:    return 11'sd65;
            4'd2:    return 11'sd49;
            4'd3:    return 11'sd27;
            4'd4:    return 11'sd0;
            4'd5:    return -11'sd27;
            4'd6:    return -11'sd49;
            4'd7:    return -11'sd65;
            4'd8:    return -11'sd70;
            4'd9:    return -11'sd65;
            4'd10:   return -11'sd49;
            4'd11:   return -11'sd27;
            4'd12:   return 11'sd0;
            4'd13:   return 11'sd27;
            4'd14:   return 11'sd49;
            default: return 11'sd65;
        endcase
    endfunction

    function automatic s11_t off_y(input logic [3:0] k);
        return -off_x(k + 4'd12);
    endfunction

    state_t        state_q;
    logic [7:0]    key_prev;
    logic [CW-1:0] frame_cnt;
    s11_t          vx, vy;
    logic          throw_ev, abort_ev, step_tick;
    s11_t          rel_ox, rel_oy, neg_ox, rel_vx, rel_vy;
    logic [9:0]    swing_x, swing_y;
    s11_t          nx, ny;
    logic [9:0]    flight_x, flight_y;
    logic          land;
`ifdef SWING_ACCEL_EN
    logic [CW-1:0] step_period;
    logic [1:0]    revs;
`endif

    assign throw_ev = (keycode == KEY_THROW) && (key_prev != KEY_THROW);
    assign abort_ev = (keycode == KEY_ABORT) && (key_prev != KEY_ABORT);
    assign state    = state_q;

    always_comb begin
        rel_ox  = off_x(angle_idx);
        rel_oy  = off_y(angle_idx);
        neg_ox  = -rel_ox;
        // Pixel sums wrap mod 1024; every on-screen result fits, so the top bit is never needed.
        swing_x = CX10 + rel_ox[9:0];
        swing_y = CY10 + rel_oy[9:0];
`ifdef SWING_ACCEL_EN
        step_tick = (frame_cnt == step_period - CW'(1));
        rel_vx    = rel_oy >>> (2'd3 - revs);
        rel_vy    = neg_ox >>> (2'd3 - revs);
`else
        step_tick = (frame_cnt == STEP_LAST);
        rel_vx    = rel_oy >>> 3;
        rel_vy    = neg_ox >>> 3;
`endif
        nx       = $signed({1'b0, sprite_x}) + vx;
        ny       = $signed({1'b0, sprite_y}) + vy;
        land     = 1'b0;
        flight_x = nx[9:0];
        flight_y = ny[9:0];
        if (nx < XMIN_S) begin
            flight_x = XMIN_S[9:0];
            land     = 1'b1;
        end else if (nx > XMAX_S) begin
            flight_x = XMAX_S[9:0];
            land     = 1'b1;
        end
        if (ny < YMIN_S) begin
            flight_y = YMIN_S[9:0];
            land     = 1'b1;
        end else if (ny > YMAX_S) begin
            flight_y = YMAX_S[9:0];
            land     = 1'b1;
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            key_prev    <= '0;
            frame_cnt   <= '0;
            vx          <= '0;
            vy          <= '0;
            angle_idx   <= '0;
            throws      <= '0;
            sprite_x    <= REST_X;
            sprite_y    <= REST_Y;
`ifdef SWING_ACCEL_EN
            step_period <= CW'(STEP_FRAMES);
            revs        <= '0;
`endif
        end else begin
            key_prev <= keycode;
            if (abort_ev) begin
                state_q   <= IDLE;
                angle_idx <= '0;
                sprite_x  <= REST_X;
                sprite_y  <= REST_Y;
            end else begin
                case (state_q)
                    IDLE: begin
                        angle_idx <= '0;
                        sprite_x  <= REST_X;
                        sprite_y  <= REST_Y;
                        if (throw_ev) begin
                            state_q   <= SWING;
                            frame_cnt <= '0;
`ifdef SWING_ACCEL_EN
                            step_period <= CW'(STEP_FRAMES);
                            revs        <= '0;
`endif
                        end
                    end
                    SWING: begin
                        if (throw_ev) begin
                            // Release freezes the sprite and skips any coinciding angle step.
                            vx      <= rel_vx;
                            vy      <= rel_vy;
                            state_q <= FLIGHT;
                        end else begin
                            sprite_x <= swing_x;
                            sprite_y <= swing_y;
                            if (step_tick) begin
                                angle_idx <= angle_idx + 4'd1;
                                frame_cnt <= '0;
`ifdef SWING_ACCEL_EN
                                if (angle_idx == 4'd15) begin
                                    if (step_period > CW'(1))
                                        step_period <= step_period - CW'(1);
                                    if (revs != 2'd2)
                                        revs <= revs + 2'd1;
                                end
`endif
                            end else begin
                                frame_cnt <= frame_cnt + CW'(1);
                            end
                        end
                    end
                    FLIGHT: begin
                        sprite_x <= flight_x;
                        sprite_y <= flight_y;
                        if (land) begin
                            state_q   <= LANDED;
                            frame_cnt <= '0;
                            throws    <= throws + 8'd1;
                        end
                    end
                    LANDED: begin
                        if (frame_cnt == HOLD_LAST) begin
                            state_q   <= IDLE;
                            angle_idx <= '0;
                            sprite_x  <= REST_X;
                            sprite_y  <= REST_Y;
                        end else begin
                            frame_cnt <= frame_cnt + CW'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hammer_swing_sequencer.sv
// Bench for hammer_swing_sequencer: directed vector table, reset/wrap sequences, and a
// randomized keycode run checked against a frame-count based reference model.
module tb_hammer_swing_sequencer;

    localparam int PX = 320;
    localparam int PY = 240;

    logic       Reset;
    logic       frame_clk;
    logic [7:0] keycode;
    logic [9:0] sprite_x;
    logic [9:0] sprite_y;
    logic [1:0] state;
    logic [3:0] angle_idx;
    logic [7:0] throws;

    hammer_swing_sequencer dut (
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .keycode   (keycode),
        .sprite_x  (sprite_x),
        .sprite_y  (sprite_y),
        .state     (state),
        .angle_idx (angle_idx),
        .throws    (throws)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    int n_asserts = 0;
    int n_fail    = 0;

    function automatic void check(input string nm, input int act, input int exp);
        n_asserts++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endfunction

    // Reference model: swing angle derived from frames spent swinging, landing hold from frames landed.
    int ox_tab[16] = '{70, 65, 49, 27, 0, -27, -49, -65, -70, -65, -49, -27, 0, 27, 49, 65};
    int m_st, m_ang, m_x, m_y, m_thr, m_vx, m_vy, m_kprev, m_sf, m_lf;

    function automatic int oy(input int k);
        return -ox_tab[(k + 12) % 16];
    endfunction

    function automatic int fdiv8(input int a);
        if (a >= 0) return a / 8;
        return -((-a + 7) / 8);
    endfunction

    task automatic model_reset();
        m_st = 0; m_ang = 0; m_x = PX + 70; m_y = PY; m_thr = 0;
        m_vx = 0; m_vy = 0; m_kprev = 0; m_sf = 0; m_lf = 0;
    endtask

    task automatic model_step(input int key);
        bit thr_e, ab_e, hit;
        int nx, ny, a;
        thr_e   = (key == 'h2C) && (m_kprev != 'h2C);
        ab_e    = (key == 'h29) && (m_kprev != 'h29);
        m_kprev = key;
        if (ab_e) begin
            m_st = 0; m_ang = 0; m_x = PX + 70; m_y = PY;
        end else begin
            case (m_st)
                0: begin
                    m_x = PX + 70; m_y = PY; m_ang = 0;
                    if (thr_e) begin m_st = 1; m_sf = 0; end
                end
                1: begin
                    if (thr_e) begin
                        m_vx = fdiv8(oy(m_ang));
                        m_vy = fdiv8(-ox_tab[m_ang]);
                        m_st = 2;
                    end else begin
                        m_sf++;
                        a     = ((m_sf - 1) / 4) % 16;
                        m_x   = PX + ox_tab[a];
                        m_y   = PY + oy(a);
                        m_ang = (m_sf / 4) % 16;
                    end
                end
                2: begin
                    nx = m_x + m_vx; ny = m_y + m_vy; hit = 0;
                    if (nx < 0)   begin nx = 0;   hit = 1; end
                    if (nx > 639) begin nx = 639; hit = 1; end
                    if (ny < 0)   begin ny = 0;   hit = 1; end
                    if (ny > 479) begin ny = 479; hit = 1; end
                    m_x = nx; m_y = ny;
                    if (hit) begin m_st = 3; m_lf = 0; m_thr = (m_thr + 1) % 256; end
                end
                default: begin
                    m_lf++;
                    if (m_lf == 60) begin m_st = 0; m_ang = 0; m_x = PX + 70; m_y = PY; end
                end
            endcase
        end
    endtask

    task automatic tick();
        @(posedge frame_clk);
        if (Reset) model_reset();
        else       model_step(int'(keycode));
        #1;
    endtask

    task automatic check_all(input string tag, input int st, input int ang, input int x, input int y, input int thr);
        check({tag, "_state"},  int'(state),     st);
        check({tag, "_angle"},  int'(angle_idx), ang);
        check({tag, "_x"},      int'(sprite_x),  x);
        check({tag, "_y"},      int'(sprite_y),  y);
        check({tag, "_throws"}, int'(throws),    thr);
    endtask

    typedef struct {
        logic [7:0] key;
        int         n;
        int         st;
        int         ang;
        int         x;
        int         y;
        int         thr;
    } vec_t;

    vec_t vt[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int waited, hold;
        logic [7:0] rkey;

        Reset = 1'b1;
        keycode = 8'h00;
        model_reset();
        #2;
        check_all("reset", 0, 0, 390, 240, 0);
        tick();
        Reset = 1'b0;

        // key, frames held, then expected state/angle/x/y/throws
        vt.push_back('{8'h00,  1, 0, 0, 390, 240, 0});
        vt.push_back('{8'h2C,  1, 1, 0, 390, 240, 0});
        vt.push_back('{8'h00,  4, 1, 1, 390, 240, 0});
        vt.push_back('{8'h00,  1, 1, 1, 385, 213, 0});
        vt.push_back('{8'h00, 12, 1, 4, 320, 170, 0});
        vt.push_back('{8'h2C,  1, 2, 4, 320, 170, 0});
        vt.push_back('{8'h00, 35, 2, 4,   5, 170, 0});
        vt.push_back('{8'h00,  1, 3, 4,   0, 170, 1});
        vt.push_back('{8'h00, 59, 3, 4,   0, 170, 1});
        vt.push_back('{8'h00,  1, 0, 0, 390, 240, 1});
        vt.push_back('{8'h2C, 20, 1, 4, 320, 170, 1});
        vt.push_back('{8'h29,  1, 0, 0, 390, 240, 1});
        vt.push_back('{8'h2C,  1, 1, 0, 390, 240, 1});
        vt.push_back('{8'h00,  1, 1, 0, 390, 240, 1});
        vt.push_back('{8'h2C,  1, 2, 0, 390, 240, 1});
        vt.push_back('{8'h00, 26, 2, 0, 390,   6, 1});
        vt.push_back('{8'h00,  1, 3, 0, 390,   0, 2});
        vt.push_back('{8'h2C,  1, 3, 0, 390,   0, 2});
        vt.push_back('{8'h00, 58, 3, 0, 390,   0, 2});
        vt.push_back('{8'h00,  1, 0, 0, 390, 240, 2});

        foreach (vt[i]) begin
            keycode = vt[i].key;
            repeat (vt[i].n) tick();
            check_all($sformatf("vec%0d", i), vt[i].st, vt[i].ang, vt[i].x, vt[i].y, vt[i].thr);
        end

        // Asynchronous reset in the middle of a flight.
        keycode = 8'h2C; tick();
        keycode = 8'h00; tick();
        keycode = 8'h2C; tick();
        keycode = 8'h00; repeat (5) tick();
        check("midflight_state", int'(state), 2);
        check("midflight_y", int'(sprite_y), 240 - 45);
        #3 Reset = 1'b1;
        #1;
        check_all("rst_async", 0, 0, 390, 240, 0);
        tick();
        Reset = 1'b0;
        tick();
        check_all("rst_next", 0, 0, 390, 240, 0);

        // 256 quick throws, each cut short by ESC once landed, to exercise the throw counter wrap.
        for (int t = 0; t < 256; t++) begin
            keycode = 8'h2C; tick();
            keycode = 8'h00; tick();
            keycode = 8'h2C; tick();
            keycode = 8'h00;
            waited = 0;
            while (state != 2'd3 && waited < 40) begin
                tick();
                waited++;
            end
            if (state != 2'd3) begin
                check("wrap_land_timeout", int'(state), 3);
                break;
            end
            if (t == 254) check("throws_255", int'(throws), 255);
            keycode = 8'h29; tick();
            check("wrap_abort_state", int'(state), 0);
        end
        check("throws_wrap", int'(throws), 0);
        check("wrap_vs_model", int'(throws), m_thr);

        // Randomized keycodes, held for a few frames each, against the reference model.
        hold = 0;
        rkey = 8'h00;
        for (int f = 0; f < 3000; f++) begin
            if (hold == 0) begin
                int r;
                r = int'($urandom_range(0, 99));
                if (r < 10)      rkey = 8'h2C;
                else if (r < 12) rkey = 8'h29;
                else if (r < 80) rkey = 8'h00;
                else             rkey = 8'($urandom_range(1, 255));
                hold = int'($urandom_range(1, 4));
            end
            keycode = rkey;
            hold--;
            tick();
            check_all("rand", m_st, m_ang, m_x, m_y, m_thr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
